// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers; optional burst lock.
// Zero-cycle req_valid->fifo_w_en path; fifo_full stalls the current grant and drops every req_ready.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_w_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  input  logic                       fifo_full,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam logic [IDW:0]  NREQ       = (IDW+1)'(NUM_REQ);
  localparam logic [IDW:0]  ONE        = (IDW+1)'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || WIDTH < 1 || DEPTH < 1) begin : g_param_check
    $error("fifo_wr_arbiter: illegal parameter set");
  end

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;

  logic           arb_hit;
  logic [IDW-1:0] arb_id;
  logic [IDW-1:0] idx;
  logic           sel_valid;
  logic [IDW-1:0] sel_id;
  logic           accept;

  // Modulo-NUM_REQ add; the sum of two in-range ids always fits in IDW+1 bits.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id, input logic [IDW:0] step);
    logic [IDW:0] s;
    s = {1'b0, id} + step;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Scan downward so the candidate closest to ptr is the last (winning) assignment.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = wrap_inc(ptr_q, (IDW+1)'(k));
      if (req_valid[idx]) begin
        arb_hit = 1'b1;
        arb_id  = idx;
      end
    end
  end

  always_comb begin
    if (state_q == ARB) begin
      sel_valid = arb_hit;
      sel_id    = arb_id;
    end else begin
      sel_valid = req_valid[owner_q];
      sel_id    = owner_q;
    end
  end

  assign accept = sel_valid & ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            ptr_d = wrap_inc(sel_id, ONE);
          end else begin
            state_d = BURST;
            owner_d = sel_id;
            bcnt_d  = BW'(1);
          end
        end
      end
      BURST: begin
        // Owner dropping valid ends the burst with an idle cycle; a full FIFO just holds.
        if (!sel_valid || (accept && bcnt_q == BURST_LAST)) begin
          state_d = ARB;
          ptr_d   = wrap_inc(owner_q, ONE);
          bcnt_d  = '0;
        end else if (accept) begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    if (rst_n && sel_valid) begin
      grant_valid       = 1'b1;
      grant_id          = sel_id;
      fifo_data_in      = req_data[sel_id*WIDTH +: WIDTH];
      fifo_w_en         = ~fifo_full;
      req_ready[sel_id] = ~fifo_full;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: burst (MAX_BURST=2) and pure round-robin (MAX_BURST=1) instances
// share stimulus and are each checked every cycle against a transaction-level grant model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int FDEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic           fifo_full = 1'b0;

  logic [N-1:0] rdy0, rdy1;
  logic         wen0, wen1;
  logic [W-1:0] din0, din1;
  logic         gv0, gv1;
  logic [1:0]   gid0, gid1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(FDEPTH), .MAX_BURST(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy0), .fifo_w_en(wen0), .fifo_data_in(din0), .fifo_full(fifo_full),
    .grant_valid(gv0), .grant_id(gid0)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(FDEPTH), .MAX_BURST(1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .fifo_w_en(wen1), .fifo_data_in(din1), .fifo_full(fifo_full),
    .grant_valid(gv1), .grant_id(gid1)
  );

  int errors = 0;
  int checks = 0;

  // Model: whoever holds the grant keeps it for up to mb consecutive writes, then
  // priority restarts just after them; -1 means nobody holds a grant.
  int m_prio  [2];
  int m_owner [2];
  int m_used  [2];

  logic [W-1:0] prod_q [N][$];
  logic [W-1:0] fifo_q [$];
  bit           directed = 1'b1;
  logic [1:0]   last_gid0, last_gid1;
  logic         last_gv0;

  function automatic int mb_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prio[k]  = 0;
      m_owner[k] = -1;
      m_used[k]  = 0;
    end
  endtask

  task automatic model_expect(input int k, output logic egv, output int egid);
    bit found;
    found = 1'b0;
    egv   = 1'b0;
    egid  = 0;
    if (rst_n === 1'b1) begin
      if (m_owner[k] >= 0) begin
        if (req_valid[m_owner[k]]) begin
          egv  = 1'b1;
          egid = m_owner[k];
        end
      end else begin
        for (int j = 0; j < N; j++) begin
          if (!found && req_valid[(m_prio[k] + j) % N]) begin
            found = 1'b1;
            egv   = 1'b1;
            egid  = (m_prio[k] + j) % N;
          end
        end
      end
    end
  endtask

  task automatic release_grant(input int k);
    m_prio[k]  = (m_owner[k] + 1) % N;
    m_owner[k] = -1;
    m_used[k]  = 0;
  endtask

  task automatic model_update(input int k, input logic egv, input int egid);
    bit acc;
    acc = egv && !fifo_full;
    if (rst_n !== 1'b1) begin
      m_prio[k]  = 0;
      m_owner[k] = -1;
      m_used[k]  = 0;
    end else if (m_owner[k] >= 0) begin
      if (!req_valid[m_owner[k]]) begin
        release_grant(k);
      end else if (acc) begin
        m_used[k]++;
        if (m_used[k] == mb_of(k)) release_grant(k);
      end
    end else if (acc) begin
      if (mb_of(k) == 1) begin
        m_prio[k] = (egid + 1) % N;
      end else begin
        m_owner[k] = egid;
        m_used[k]  = 1;
      end
    end
  endtask

  task automatic drive_inputs();
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = prod_q[i][0];
      end
    end
    fifo_full = (fifo_q.size() >= FDEPTH);
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) prod_q[i].delete();
  endtask

  // One clock: drive, check both instances mid-cycle, advance models, then let the
  // producers and the FIFO react to what the burst-lock instance actually did.
  task automatic cycle(input bit rd);
    logic         egv;
    int           egid;
    logic [N-1:0] erdy;
    logic [W-1:0] edat;
    bit           eacc;
    logic [N-1:0] rdy_s;
    logic         wen_s;
    logic [W-1:0] din_s;
    if (directed) drive_inputs();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_expect(k, egv, egid);
      eacc = egv && !fifo_full;
      erdy = '0;
      if (eacc) erdy[egid] = 1'b1;
      edat = egv ? req_data[egid*W +: W] : '0;
      if (k == 0) begin
        chk("grant_valid_b2", 32'(gv0), 32'(egv));
        chk("grant_id_b2", 32'(gid0), egid);
        chk("req_ready_b2", 32'(rdy0), 32'(erdy));
        chk("fifo_w_en_b2", 32'(wen0), 32'(eacc));
        chk("fifo_data_b2", 32'(din0), 32'(edat));
      end else begin
        chk("grant_valid_b1", 32'(gv1), 32'(egv));
        chk("grant_id_b1", 32'(gid1), egid);
        chk("req_ready_b1", 32'(rdy1), 32'(erdy));
        chk("fifo_w_en_b1", 32'(wen1), 32'(eacc));
        chk("fifo_data_b1", 32'(din1), 32'(edat));
      end
      model_update(k, egv, egid);
    end
    last_gid0 = gid0;
    last_gid1 = gid1;
    last_gv0  = gv0;
    rdy_s     = rdy0;
    wen_s     = wen0;
    din_s     = din0;
    @(posedge clk);
    #1;
    if (directed) begin
      if (rd && fifo_q.size() > 0) fifo_q.delete(0);
      if (wen_s) fifo_q.push_back(din_s);
      for (int i = 0; i < N; i++) begin
        if (rdy_s[i] && prod_q[i].size() > 0) prod_q[i].delete(0);
      end
    end
  endtask

  initial begin
    int exp_b2 [5];
    int exp_b1 [5];
    exp_b2 = '{0, 0, 3, 3, 0};
    exp_b1 = '{0, 3, 0, 3, 0};
    model_reset();
    clear_producers();
    fifo_q.delete();

    // Reset held with every producer valid, then burst fairness until the FIFO fills.
    for (int i = 0; i < N; i++) begin
      prod_q[i].push_back(W'(16 * i));
      prod_q[i].push_back(W'(16 * i + 1));
    end
    repeat (2) cycle(1'b0);
    chk("rst_grant_valid", 32'(gv0), 32'd0);
    chk("rst_req_ready", 32'(rdy0), 32'd0);
    rst_n = 1'b1;
    cycle(1'b0);
    chk("first_grant_id", 32'(last_gid0), 32'd0);
    repeat (7) cycle(1'b0);
    chk("fair_fill_level", fifo_q.size(), FDEPTH);
    for (int j = 0; j < FDEPTH; j++) begin
      chk("fair_order", 32'(fifo_q[j]), 16 * (j / 2) + (j % 2));
    end
    for (int i = 0; i < N; i++) prod_q[i].push_back(W'(8'h40 + i));
    repeat (3) cycle(1'b0);
    chk("full_no_ready", 32'(rdy0), 32'd0);
    chk("full_level", fifo_q.size(), FDEPTH);

    // Full stall with producer 2 alone; each read lets exactly one word in.
    clear_producers();
    prod_q[2].push_back(8'hA2);
    prod_q[2].push_back(8'hA3);
    repeat (2) cycle(1'b0);
    chk("stall_level", fifo_q.size(), FDEPTH);
    cycle(1'b1);
    chk("stall_after_read", fifo_q.size(), FDEPTH - 1);
    cycle(1'b0);
    chk("stall_write_data", 32'(fifo_q[FDEPTH-1]), 32'hA2);
    cycle(1'b0);
    chk("stall_hold_level", fifo_q.size(), FDEPTH);
    cycle(1'b1);
    cycle(1'b0);
    chk("stall_second_data", 32'(fifo_q[FDEPTH-1]), 32'hA3);

    // Early release: owner drops valid after one word, costing one idle cycle.
    fifo_q.delete();
    clear_producers();
    prod_q[1].push_back(8'h51);
    cycle(1'b0);
    chk("early_grant_id", 32'(last_gid0), 32'd1);
    cycle(1'b0);
    chk("early_idle", 32'(last_gv0), 32'd0);
    prod_q[0].push_back(8'h50);
    prod_q[3].push_back(8'h53);
    cycle(1'b0);
    chk("early_next_id", 32'(last_gid0), 32'd3);
    repeat (2) cycle(1'b0);

    // Wrap: only producers 3 and 0 valid, from a fresh reset.
    rst_n = 1'b0;
    cycle(1'b0);
    rst_n = 1'b1;
    fifo_q.delete();
    clear_producers();
    for (int j = 0; j < 6; j++) begin
      prod_q[0].push_back(W'(8'h60 + j));
      prod_q[3].push_back(W'(8'h70 + j));
    end
    for (int j = 0; j < 5; j++) begin
      cycle(1'b0);
      chk("wrap_seq_b2", 32'(last_gid0), exp_b2[j]);
      chk("wrap_seq_b1", 32'(last_gid1), exp_b1[j]);
    end

    // Reset mid-burst: outputs clear at once, next grant restarts at id 0.
    rst_n = 1'b0;
    cycle(1'b0);
    rst_n = 1'b1;
    fifo_q.delete();
    clear_producers();
    prod_q[2].push_back(8'hC0);
    prod_q[2].push_back(8'hC1);
    cycle(1'b0);
    chk("midburst_owner", 32'(last_gid0), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant_valid", 32'(gv0), 32'd0);
    chk("midrst_w_en", 32'(wen0), 32'd0);
    chk("midrst_ready", 32'(rdy0), 32'd0);
    chk("midrst_data", 32'(din0), 32'd0);
    chk("midrst_grant_id", 32'(gid0), 32'd0);
    model_reset();
    for (int i = 0; i < N; i++) prod_q[i].push_back(W'(8'hD0 + i));
    cycle(1'b0);
    rst_n = 1'b1;
    cycle(1'b0);
    chk("post_rst_first_id", 32'(last_gid0), 32'd0);

    // Random valid/data/full/reset, including valid drops that end bursts early.
    directed = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      cycle(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous_fifo write port among NUM_REQ independent producers. Each producer uses a valid/ready handshake. The arbiter picks one producer, drives the FIFO w_en/data_in for it, and honours the FIFO full flag. An optional burst lock keeps ownership with one producer for up to MAX_BURST consecutive writes. The FIFO read side is not touched by this block.

Parameters:
NUM_REQ, 4, number of producers (2..16)
WIDTH, 8, data width; matches the FIFO WIDTH
DEPTH, 8, FIFO depth; informational only, not used in logic
MAX_BURST, 2, maximum consecutive accepted writes per grant (1 = pure round-robin)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  producer i has a word pending
req_data  in  NUM_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot (or zero); word of producer i accepted this cycle when valid[i] and ready[i]
fifo_w_en  out  1  to FIFO w_en
fifo_data_in  out  WIDTH  to FIFO data_in
fifo_full  in  1  from FIFO full
grant_valid  out  1  a producer is currently selected
grant_id  out  $clog2(NUM_REQ)  index of the selected producer (0 when grant_valid=0)

Behaviour:
- Registered state:
  - state: ARB or BURST
  - ptr: round-robin priority pointer
  - owner: current burst owner id
  - bcnt: writes accepted in the current burst, width $clog2(MAX_BURST+1)
- Datapath is combinational from the current state and inputs. Latency from req_valid to fifo_w_en is 0 cycles. The FIFO captures data at the next clk edge.
- Reset (async, rst_n=0): state=ARB, ptr=0, owner=0, bcnt=0.
  - Outputs forced while rst_n=0: req_ready=0, fifo_w_en=0, fifo_data_in=0, grant_valid=0, grant_id=0.
- Selection in ARB: select the first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - grant_valid=1 if any valid, grant_id=i.
- Selection in BURST: the selected id is owner, if req_valid[owner]=1.
  - Otherwise nothing is selected (grant_valid=0) for that one cycle.
- Accept rule: accept = grant_valid & ~fifo_full.
  - req_ready[grant_id] = accept; all other ready bits 0.
  - fifo_w_en = accept.
  - fifo_data_in = req_data slice of grant_id when grant_valid, else 0.
- Handshake rules:
  - A producer holds valid and data stable until ready.
  - Dropping valid before ready is illegal but harmless: no write occurs.
- Transitions:
  - ARB, accept, MAX_BURST=1: stay in ARB, ptr <= grant_id+1 mod NUM_REQ.
  - ARB, accept, MAX_BURST>1: go to BURST, owner <= grant_id, bcnt <= 1.
  - ARB, no accept (full or no valid): no change; ptr does not move.
  - BURST, accept: bcnt+1. If bcnt+1 == MAX_BURST, go to ARB with ptr <= owner+1 mod NUM_REQ and bcnt <= 0.
  - BURST, req_valid[owner]=0: go to ARB, ptr <= owner+1, bcnt <= 0. That cycle is idle.
  - BURST, fifo_full with owner valid: hold; no write; other producers are not granted.
- Boundary conditions:
  - Wrap: ptr = NUM_REQ-1 wraps to 0.
  - fifo_full asserted in the same cycle as a valid grant: no write, no pointer or counter change.
  - Simultaneous FIFO read in the same cycle does not matter here; only fifo_full is consulted.
  - Reset mid-burst: the burst is abandoned immediately and the next grant starts from ptr=0.
- Fairness: with all producers continuously valid and no full, each producer gets exactly MAX_BURST writes per NUM_REQ*MAX_BURST cycles.

Test Plan:
1. Reset: hold rst_n=0 for 10 time units with all req_valid=1 → req_ready=0, fifo_w_en=0, grant_valid=0. After release, first grant is id 0.
2. Fairness: NUM_REQ=4, MAX_BURST=2, all valid, producer i sends 0x10*i+k, no reads → FIFO receives 0x00,0x01,0x10,0x11,0x20,0x21,0x30,0x31. Then full=1 and all ready stay 0 until a read.
3. Full stall: fill the FIFO to 8 entries, then raise req_valid[2] only → no write while full. After one read, exactly one write of req_data[2] occurs and ptr is unchanged until the burst ends.
4. Early release: MAX_BURST=2, only req_valid[1] for one word, then dropped → one write, one idle cycle. Next grant among {0,3} valid picks 3 (ptr=2, id 2 idle).
5. Wrap: only req_valid[3] and [0] valid, MAX_BURST=1 → writes alternate 3,0,3,0.
6. Reset mid-burst: assert rst_n=0 after the first write of owner 2 → outputs 0 immediately. After release, with all valid, id 0 is granted first.
